// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Memory stage. Runs one load or store per access against a
//               word-organised memory over req/ack, returns extended data.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_is_load,
    input  logic                  i_is_store,
    input  logic [2:0]            i_funct3,
    input  logic [DATA_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [4:0]            i_rd,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [DATA_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic [3:0]            o_mem_be,
    input  logic                  i_mem_ack,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_done,
    output logic                  o_wb_en,
    output logic [4:0]            o_wb_rd,
    output logic [DATA_WIDTH-1:0] o_wb_data,
    output logic                  o_fault
);

    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? c_CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [2:0]            r_funct3;
    logic [4:0]            r_rd;
    logic                  r_is_load;
    logic                  r_fault;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [4:0]            r_wb_rd;
    logic [DATA_WIDTH-1:0] r_wb_data;

    logic                  w_busy;
    logic                  w_accept;
    logic                  w_f3_ok;
    logic                  w_misaligned;
    logic                  w_reject;
    logic                  w_timeout;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_load_val;
    logic [DATA_WIDTH-1:0] w_st_data;
    logic [3:0]            w_st_be;

    assign w_busy   = (r_state == S_BUSY);
    assign o_ready  = !w_busy;
    assign w_accept = i_valid && o_ready;

    // Legality and alignment are judged on the raw inputs in the accept cycle.
    always_comb begin
        w_f3_ok = 1'b0;
        if (i_is_load && !i_is_store) begin
            case (i_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3_ok = 1'b1;
                default:                                w_f3_ok = 1'b0;
            endcase
        end else if (i_is_store && !i_is_load) begin
            case (i_funct3)
                3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
                default:                w_f3_ok = 1'b0;
            endcase
        end
        w_misaligned = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                       ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
        w_reject     = !w_f3_ok || w_misaligned;
    end

    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == c_CNT_LAST);

    always_comb begin
        w_byte = i_mem_rdata[8*r_addr[1:0] +: 8];
        w_half = r_addr[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_val = {24'd0, w_byte};
            3'b101:  w_load_val = {16'd0, w_half};
            default: w_load_val = i_mem_rdata;
        endcase
    end

    always_comb begin
        w_st_data = '0;
        w_st_be   = 4'b0000;
        if (!r_is_load) begin
            case (r_funct3[1:0])
                2'b00: begin
                    w_st_data = {4{r_wdata[7:0]}};
                    w_st_be   = 4'b0001 << r_addr[1:0];
                end
                2'b01: begin
                    w_st_data = {2{r_wdata[15:0]}};
                    w_st_be   = r_addr[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    w_st_data = r_wdata;
                    w_st_be   = 4'b1111;
                end
            endcase
        end
    end

    assign o_mem_req   = w_busy;
    assign o_mem_we    = w_busy && !r_is_load;
    assign o_mem_addr  = w_busy ? {r_addr[DATA_WIDTH-1:2], 2'b00} : '0;
    assign o_mem_wdata = w_busy ? w_st_data : '0;
    assign o_mem_be    = w_busy ? w_st_be : 4'b0000;
    assign o_done      = (r_state == S_DONE);
    assign o_fault     = o_done && r_fault;
    assign o_wb_en     = o_done && r_is_load && !r_fault && (r_wb_rd != 5'd0);
    assign o_wb_rd     = r_wb_rd;
    assign o_wb_data   = r_wb_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_funct3  <= 3'b000;
            r_rd      <= 5'd0;
            r_is_load <= 1'b0;
            r_fault   <= 1'b0;
            r_cnt     <= '0;
            r_wb_rd   <= 5'd0;
            r_wb_data <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_addr    <= i_addr;
                        r_wdata   <= i_wdata;
                        r_funct3  <= i_funct3;
                        r_rd      <= i_rd;
                        r_is_load <= i_is_load;
                        r_fault   <= w_reject;
                        r_cnt     <= '0;
                        if (w_reject) begin
                            r_state <= S_DONE;
                            r_wb_rd <= i_rd;
                        end else begin
                            r_state <= S_BUSY;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    // An ack in the expiry cycle still completes normally.
                    if (i_mem_ack) begin
                        r_state <= S_DONE;
                        r_wb_rd <= r_rd;
                        if (r_is_load) begin
                            r_wb_data <= w_load_val;
                        end
                    end else if (w_timeout) begin
                        r_state <= S_DONE;
                        r_fault <= 1'b1;
                        r_wb_rd <= r_rd;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Scoreboard bench for load_store_unit with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        i_is_load = 1'b0;
    logic        i_is_store = 1'b0;
    logic [2:0]  i_funct3 = 3'b000;
    logic [31:0] i_addr = '0;
    logic [31:0] i_wdata = '0;
    logic [4:0]  i_rd = '0;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_be;
    logic        i_mem_ack = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        o_done;
    logic        o_wb_en;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;
    logic        o_fault;

    load_store_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_is_load(i_is_load), .i_is_store(i_is_store), .i_funct3(i_funct3),
        .i_addr(i_addr), .i_wdata(i_wdata), .i_rd(i_rd),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be), .i_mem_ack(i_mem_ack),
        .i_mem_rdata(i_mem_rdata), .o_done(o_done), .o_wb_en(o_wb_en),
        .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data), .o_fault(o_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          fault;
        bit          wb_en;
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } done_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          len;
    } req_t;

    done_t done_q[$];
    req_t  req_q[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: derived directly from the RV32I width/sign rules.
    function automatic void model(input bit ld, input bit st, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] rdata, output bit fault,
                                  output logic [31:0] wbd, output logic [31:0] mwd,
                                  output logic [3:0] be);
        bit ok;
        int sz, lane;
        logic [31:0] v;
        ok = 1'b0;
        if (ld && !st)      ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        else if (st && !ld) ok = (f3 inside {3'd0, 3'd1, 3'd2});
        sz = 1 << f3[1:0];
        if (ok && (addr % sz) != 0) ok = 1'b0;
        fault = !ok;
        lane  = int'(addr % 4);
        wbd = '0; mwd = '0; be = 4'b0000;
        if (ld) begin
            case (f3)
                3'd0, 3'd4: begin
                    v = (rdata >> (8 * lane)) & 32'hFF;
                    if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
                    wbd = v;
                end
                3'd1, 3'd5: begin
                    v = (rdata >> ((lane >= 2) ? 16 : 0)) & 32'hFFFF;
                    if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
                    wbd = v;
                end
                default: wbd = rdata;
            endcase
        end else begin
            case (f3)
                3'd0: begin mwd = (wdata & 32'hFF) * 32'h0101_0101; be = 4'(1 << lane); end
                3'd1: begin mwd = (wdata & 32'hFFFF) * 32'h0001_0001; be = (lane >= 2) ? 4'hC : 4'h3; end
                default: begin mwd = wdata; be = 4'hF; end
            endcase
        end
    endfunction

    // d in [0,T-1] acks in BUSY cycle d+1; any other d never acks.
    task automatic access(input bit ld, input bit st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd, input logic [31:0] rdata, input int d);
        bit fault, ack, rdy;
        logic [31:0] wbd, mwd;
        logic [3:0]  be;
        int n, a;
        done_t de;
        req_t  re;
        model(ld, st, f3, addr, wdata, rdata, fault, wbd, mwd, be);
        ack = (d >= 0) && (d < T);
        i_valid = 1'b1; i_is_load = ld; i_is_store = st; i_funct3 = f3;
        i_addr = addr; i_wdata = wdata; i_rd = rd;
        n = 0;
        forever begin
            @(negedge clk); rdy = o_ready;
            @(posedge clk); #1;
            if (rdy) break;
            n++;
            if (n > 50) begin
                errors++; checks++;
                $display("FAIL accept_wait: o_ready stayed 0 for %0d cycles, required 1", n);
                i_valid = 1'b0;
                return;
            end
        end
        i_valid = 1'b0;
        a = cyc;
        de.fault = fault || !ack;
        de.wb_en = ld && !de.fault && (rd != 5'd0);
        de.rd    = rd;
        de.data  = wbd;
        de.cyc   = fault ? a : (ack ? a + d + 1 : a + T);
        done_q.push_back(de);
        if (!fault) begin
            re.we = st; re.addr = addr & 32'hFFFF_FFFC; re.wdata = mwd; re.be = be;
            re.len = ack ? d + 1 : T;
            req_q.push_back(re);
            if (ack) begin
                if (d > 0) begin repeat (d) @(posedge clk); #1; end
                i_mem_ack = 1'b1; i_mem_rdata = rdata;
                @(posedge clk); #1;
                i_mem_ack = 1'b0; i_mem_rdata = $urandom();
            end
        end
    endtask

    task automatic idle(input int k);
        if (k > 0) begin repeat (k) @(posedge clk); #1; end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: compares DUT outputs against the scoreboard queues.
    bit prev_req = 1'b0;
    int req_len  = 0;
    initial begin
        done_t dd;
        forever begin
            @(negedge clk);
            if (!i_rst_n) begin
                prev_req = 1'b0;
                req_len  = 0;
            end else begin
                if (o_mem_req) begin
                    req_len++;
                    if (req_q.size() == 0) begin
                        errors++; checks++;
                        $display("FAIL unexpected_req: o_mem_req=1 addr=0x%08h, required 0", o_mem_addr);
                    end else begin
                        check("req_we", 32'(o_mem_we), 32'(req_q[0].we));
                        check("req_addr", o_mem_addr, req_q[0].addr);
                        check("req_be", 32'(o_mem_be), 32'(req_q[0].be));
                        if (req_q[0].we) check("req_wdata", o_mem_wdata, req_q[0].wdata);
                        check("ready_busy", 32'(o_ready), 32'd0);
                    end
                end else if (prev_req) begin
                    if (req_q.size() > 0) begin
                        check("req_len", 32'(req_len), 32'(req_q[0].len));
                        void'(req_q.pop_front());
                    end
                    req_len = 0;
                end
                prev_req = o_mem_req;
                if (o_wb_en && !o_done) begin
                    errors++; checks++;
                    $display("FAIL wb_en_outside_done: o_wb_en=1 with o_done=0, required 0");
                end
                if (o_done) begin
                    if (done_q.size() == 0) begin
                        errors++; checks++;
                        $display("FAIL unexpected_done: o_done=1, required 0");
                    end else begin
                        dd = done_q.pop_front();
                        check("done_cycle", 32'(cyc), 32'(dd.cyc));
                        check("fault", 32'(o_fault), 32'(dd.fault));
                        check("wb_en", 32'(o_wb_en), 32'(dd.wb_en));
                        if (dd.wb_en) begin
                            check("wb_rd", 32'(o_wb_rd), 32'(dd.rd));
                            check("wb_data", o_wb_data, dd.data);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] lf3[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        bit ld, st;
        logic [2:0] f3;
        logic [31:0] addr;
        int sel;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_req", 32'(o_mem_req), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_wb_data", o_wb_data, 32'd0);
        check("rst_be", 32'(o_mem_be), 32'd0);
        i_rst_n = 1'b1;
        idle(1);

        access(1, 0, 3'd0, 32'h103, 32'h0, 5'd5, 32'h80FF_1234, 0);
        access(1, 0, 3'd4, 32'h103, 32'h0, 5'd5, 32'h80FF_1234, 0);
        access(0, 1, 3'd1, 32'h202, 32'h1234_ABCD, 5'd0, 32'h0, 1);
        access(1, 0, 3'd2, 32'h006, 32'h0, 5'd7, 32'h0, 0);
        access(1, 0, 3'd3, 32'h010, 32'h0, 5'd7, 32'h0, 0);
        idle(2);
        access(1, 0, 3'd1, 32'h040, 32'h0, 5'd9, 32'h0000_8001, 5);
        access(0, 1, 3'd2, 32'h044, 32'hDEAD_BEEF, 5'd0, 32'h0, 0);
        access(1, 0, 3'd2, 32'h050, 32'h0, 5'd3, 32'h0, -1);
        access(1, 0, 3'd5, 32'h052, 32'h0, 5'd4, 32'hF00D_8765, 3);
        access(0, 1, 3'd0, 32'h061, 32'h0000_00A5, 5'd0, 32'h0, 2);

        // Reset in the middle of an outstanding load.
        i_valid = 1'b1; i_is_load = 1'b1; i_is_store = 1'b0; i_funct3 = 3'd2;
        i_addr = 32'h300; i_rd = 5'd3;
        @(negedge clk);
        @(posedge clk); #1;
        i_valid = 1'b0;
        #2;
        i_rst_n = 1'b0;
        #1;
        check("midrst_req", 32'(o_mem_req), 32'd0);
        check("midrst_ready", 32'(o_ready), 32'd1);
        check("midrst_wb_rd", 32'(o_wb_rd), 32'd0);
        check("midrst_wb_data", o_wb_data, 32'd0);
        @(posedge clk); #1;
        i_rst_n = 1'b1;
        i_mem_ack = 1'b1; i_mem_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        i_mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("late_ack_done", 32'(o_done), 32'd0);
        end
        @(posedge clk); #1;
        access(1, 0, 3'd2, 32'h080, 32'h0, 5'd0, 32'h7654_3210, 0);

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            ld = (sel <= 5) || (sel == 9 && $urandom_range(0, 1) == 1);
            st = (sel >= 6 && sel <= 8) || (sel == 9 && ld);
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
            else if (ld)                   f3 = lf3[$urandom_range(0, 4)];
            else                           f3 = 3'($urandom_range(0, 2));
            addr = $urandom();
            if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
            access(ld, st, f3, addr, $urandom(), 5'($urandom_range(0, 31)),
                   $urandom(), $urandom_range(0, 5));
            idle($urandom_range(0, 2));
        end

        idle(10);
        check("done_q_empty", 32'(done_q.size()), 32'd0);
        check("req_q_empty", 32'(req_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
